counter_seq_checker: RTL
========================

# counter_seq_checker

Receive-side checker for the 5-bit skip counter sequence 0,1,2,3,5,7,…,29,31,0 (18 states, period 18). It samples a counter value each valid cycle, locks onto the sequence, and decodes each value to its ordinal position 0..17. It flags every break in the sequence and can optionally count errors and wraps. It sits downstream of the counter, on the far side of any pipeline or clock-domain-free link, as the consumer and monitor of that counter's output.

## Interface
- LOCK_N, 2, consecutive correct transitions required to declare lock (legal range 1..15)
- CNT_W, 8, width of statistics counters
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- q_in  in  5  counter value under check
- in_valid  in  1  q_in is sampled on this edge only when 1
- cnt_clr  in  1  synchronous clear of statistics counters
- idx  out  5  ordinal of last legal sample (0..17)
- idx_vld  out  1  one-cycle pulse: idx updated from a legal sample
- locked  out  1  checker in LOCKED state
- err  out  1  one-cycle pulse: sequence break while LOCKED
- wrap  out  1  one-cycle pulse: matched 31→0 transition while LOCKED
- err_cnt  out  CNT_W  saturating error count
- wrap_cnt  out  CNT_W  saturating wrap count

## Operation
- legal(v): v≤3, or v odd. Even v in 4..30 is illegal.
- nxt(v): v=31 → 0; v>2 → v+2; else v+1. All arithmetic is 5-bit.
- ord(v): v≤3 → v; else (v+3)>>1. 5→4, 7→5, 31→17. Use a 6-bit intermediate so there is no overflow.
- On every sample with legal q_in: idx←ord(q_in), idx_vld=1. On an illegal sample, idx holds.
- Internal state: expected value exp[4:0], match count mcnt[3:0], FSM state {HUNT, ACQ, LOCKED}.
- HUNT:
  - legal sample → exp←nxt(q_in), mcnt←0, go to ACQ.
  - illegal sample → stay in HUNT.
- ACQ:
  - q_in==exp → exp←nxt(q_in), mcnt←mcnt+1; if mcnt+1==LOCK_N, go to LOCKED.
  - mismatch and legal → reseed: exp←nxt(q_in), mcnt←0, stay in ACQ.
  - illegal → go to HUNT.
  - ACQ never asserts err.
- LOCKED:
  - q_in==exp → exp←nxt(q_in). If q_in==0, wrap=1.
  - mismatch → err=1. Legal mismatch reseeds and goes to ACQ; illegal mismatch goes to HUNT.
- in_valid=0: all state, exp, mcnt and idx hold. All pulses are 0.
- Statistics counters:
  - Increment on err and wrap respectively.
  - Saturate at 2^CNT_W−1.
  - cnt_clr clears both. If cnt_clr coincides with an increment event, the result is 1.

## Timing
- All outputs are registered. Each response appears in the cycle after the sampling edge (1-cycle latency).
- Pulses are exactly one cycle wide. Back-to-back valid samples can produce back-to-back pulses.
- locked rises the cycle after the LOCK_N-th matching sample. It falls the cycle after the breaking sample, in the same cycle err is high.
- Reset values: state=HUNT, exp=0, mcnt=0, idx=0, idx_vld=0, locked=0, err=0, wrap=0, err_cnt=0, wrap_cnt=0.
- rst asserted mid-operation clears everything immediately, with no clock needed. The first valid sample after release is treated as a HUNT sample.

## Configuration
- COUNTER_SEQ_CHK_STATS_EN defined: err_cnt and wrap_cnt are implemented as described.
- COUNTER_SEQ_CHK_STATS_EN undefined: both outputs are tied to 0, no counter flops exist, and cnt_clr is ignored.
- err, wrap and all other behaviour are identical in both builds.

## Test plan
- Lock: reset, then valid samples 0,1,2 with LOCK_N=2. Required: locked=1 the cycle after sample 2. idx sequence 0,1,2, with idx_vld high each cycle.
- Full period: stream 3,5,…,31,0 after lock. Required: idx 3..17 then 0, wrap=1 exactly once (after 0), wrap_cnt=1, err never asserted.
- Break, legal: locked at exp=9, feed 11. Required: err=1 and locked=0 next cycle, err_cnt=1. Then 13,15 relock after 15.
- Break, illegal: locked, feed 6. Required: err=1, idx holds, idx_vld=0, state HUNT. Then 6,6 produce nothing. Then 7 enters ACQ.
- Gaps: locked, with in_valid low for 5 cycles between 21 and 23. Required: no pulses, locked stays 1, no err on 23.
- Saturation and clear (stats enabled, CNT_W=2): 4 legal breaks give err_cnt=3. Then cnt_clr concurrent with a 5th err gives err_cnt=1. With the macro undefined, err_cnt stays 0 throughout.

Source files
------------

// File: rtl/counter_seq_checker.sv
// Receive-side lock/decode checker for the 5-bit skip counter sequence 0,1,2,3,5,...,31,0.
// Optional statistics counters are built only when COUNTER_SEQ_CHK_STATS_EN is defined.
module counter_seq_checker #(
  parameter int unsigned LOCK_N = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       q_in,
  input  logic             in_valid,
  input  logic             cnt_clr,
  output logic [4:0]       idx,
  output logic             idx_vld,
  output logic             locked,
  output logic             err,
  output logic             wrap,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] wrap_cnt
);

  typedef enum logic [1:0] {HUNT, ACQ, LOCKED} state_t;

  localparam logic [3:0] LOCK_V = 4'(LOCK_N);

  state_t     state_q;
  logic [4:0] exp_q;
  logic [3:0] mcnt_q;
  logic [4:0] idx_q;
  logic       idx_vld_q, locked_q, err_q, wrap_q;

  logic       q_legal, q_match;
  logic [4:0] q_nxt, q_ord;
  logic [3:0] mcnt_inc;
  logic       err_d, wrap_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    q_legal  = (q_in <= 5'd3) || q_in[0];
    q_match  = (q_in == exp_q);
    mcnt_inc = mcnt_q + 4'd1;
    if (q_in == 5'd31)     q_nxt = 5'd0;
    else if (q_in > 5'd2)  q_nxt = q_in + 5'd2;
    else                   q_nxt = q_in + 5'd1;
    // 6-bit sum keeps (31+3)>>1 = 17 from overflowing.
    if (q_in <= 5'd3) q_ord = q_in;
    else              q_ord = 5'((6'(q_in) + 6'd3) >> 1);
    err_d  = in_valid && (state_q == LOCKED) && !q_match;
    wrap_d = in_valid && (state_q == LOCKED) && q_match && (q_in == 5'd0);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= HUNT;
      exp_q     <= 5'd0;
      mcnt_q    <= 4'd0;
      idx_q     <= 5'd0;
      idx_vld_q <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      idx_vld_q <= 1'b0;
      err_q     <= err_d;
      wrap_q    <= wrap_d;
      if (in_valid) begin
        if (q_legal) begin
          idx_q     <= q_ord;
          idx_vld_q <= 1'b1;
        end
        unique case (state_q)
          HUNT: begin
            if (q_legal) begin
              exp_q   <= q_nxt;
              mcnt_q  <= 4'd0;
              state_q <= ACQ;
            end
          end
          ACQ: begin
            if (q_match) begin
              exp_q  <= q_nxt;
              mcnt_q <= mcnt_inc;
              if (mcnt_inc == LOCK_V) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end else if (q_legal) begin
              exp_q  <= q_nxt;
              mcnt_q <= 4'd0;
            end else begin
              state_q <= HUNT;
            end
          end
          LOCKED: begin
            if (q_match) begin
              exp_q <= q_nxt;
            end else begin
              locked_q <= 1'b0;
              if (q_legal) begin
                exp_q   <= q_nxt;
                mcnt_q  <= 4'd0;
                state_q <= ACQ;
              end else begin
                state_q <= HUNT;
              end
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign idx     = idx_q;
  assign idx_vld = idx_vld_q;
  assign locked  = locked_q;
  assign err     = err_q;
  assign wrap    = wrap_q;

`ifdef COUNTER_SEQ_CHK_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] err_cnt_q, wrap_cnt_q;

  // A clear coinciding with an event leaves a count of 1, not 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q  <= '0;
      wrap_cnt_q <= '0;
    end else begin
      if (cnt_clr)                             err_cnt_q <= CNT_W'(err_d);
      else if (err_d && err_cnt_q != CNT_MAX)  err_cnt_q <= err_cnt_q + CNT_W'(1);
      if (cnt_clr)                             wrap_cnt_q <= CNT_W'(wrap_d);
      else if (wrap_d && wrap_cnt_q != CNT_MAX) wrap_cnt_q <= wrap_cnt_q + CNT_W'(1);
    end
  end

  assign err_cnt  = err_cnt_q;
  assign wrap_cnt = wrap_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign err_cnt  = '0;
  assign wrap_cnt = '0;
`endif

endmodule
